// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-stage program counter with a circular return-address stack.
//
// program_counter_pkg carries the branch-condition encoding and the ALU flag
// positions within status_register[3:0].
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   stall                 hold PC and RAS this cycle (clear_flags still acts)
//   imar                  register-indirect branch target
//   address_immediate     absolute target or two's-complement PC offset
//   immediate_select      1: immediate target, 0: imar
//   relative_select       with immediate_select: target = pc + address_immediate
//   jump_branch_select    branch/jump request
//   unconditional_branch  ignore branch_condition
//   call / ret            subroutine call (push pc+step, jump) / return (pop)
//   status_register       ALU flags in bits [3:0]
//   branch_condition      condition tested when the branch is conditional
//   clear_flags           clears the sticky RAS error flags
//   pc                    registered program counter
//   ras_top               top of RAS, 0 when empty
//   ras_count             number of valid RAS entries
//   ras_overflow          sticky: a push found the RAS full
//   ras_underflow         sticky: a pop found the RAS empty

package program_counter_pkg;

  // Flag positions inside status_register
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [2:0] {
    COND_ZERO             = 3'd0,
    COND_NOT_ZERO         = 3'd1,
    COND_NEGATIVE         = 3'd2,
    COND_POSITIVE         = 3'd3,
    COND_CARRY_SET        = 3'd4,
    COND_CARRY_CLEARED    = 3'd5,
    COND_OVERFLOW_SET     = 3'd6,
    COND_OVERFLOW_CLEARED = 3'd7
  } branch_condition_e;

endpackage

module pc_sequencer
  import program_counter_pkg::*;
#(
  parameter int unsigned            I_ADDR_W     = 12,
  parameter int unsigned            INST_W_BYTES = 2,
  parameter int unsigned            DATA_W       = 8,
  parameter int unsigned            RAS_DEPTH    = 4,
  parameter logic [I_ADDR_W-1:0]    RESET_VECTOR = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            stall,
  input  logic [I_ADDR_W-1:0]             imar,
  input  logic [I_ADDR_W-1:0]             address_immediate,
  input  logic                            immediate_select,
  input  logic                            relative_select,
  input  logic                            jump_branch_select,
  input  logic                            unconditional_branch,
  input  logic                            call,
  input  logic                            ret,
  input  logic [DATA_W-1:0]               status_register,
  input  branch_condition_e               branch_condition,
  input  logic                            clear_flags,
  output logic [I_ADDR_W-1:0]             pc,
  output logic [I_ADDR_W-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count,
  output logic                            ras_overflow,
  output logic                            ras_underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [I_ADDR_W-1:0] r_pc;
  logic [I_ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;   // slot the next push writes
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;
  logic                r_unf;

  logic [I_ADDR_W-1:0] w_seq_pc;
  logic [I_ADDR_W-1:0] w_target;
  logic [I_ADDR_W-1:0] w_pc_nxt;
  logic [PTR_W-1:0]    w_ptr_inc;
  logic [PTR_W-1:0]    w_ptr_dec;
  logic [3:0]          w_flags;
  logic                w_unused_status;
  logic                w_cond_met;
  logic                w_taken;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf_set;
  logic                w_unf_set;

  assign w_flags         = status_register[3:0];
  assign w_unused_status = |status_register[DATA_W-1:4];

  assign w_seq_pc = r_pc + I_ADDR_W'(INST_W_BYTES);
  assign w_target = !immediate_select ? imar
                  : relative_select   ? r_pc + address_immediate
                  :                     address_immediate;

  // Explicit wrap keeps the ring correct for non-power-of-two depths
  assign w_ptr_inc = (r_wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_ptr_dec = (r_wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_wr_ptr - 1'b1;

  always_comb begin
    w_cond_met = 1'b0;
    case (branch_condition)
      COND_ZERO:             w_cond_met =  w_flags[FLAG_Z];
      COND_NOT_ZERO:         w_cond_met = !w_flags[FLAG_Z];
      COND_NEGATIVE:         w_cond_met =  w_flags[FLAG_N];
      COND_POSITIVE:         w_cond_met = !w_flags[FLAG_N];
      COND_CARRY_SET:        w_cond_met =  w_flags[FLAG_C];
      COND_CARRY_CLEARED:    w_cond_met = !w_flags[FLAG_C];
      COND_OVERFLOW_SET:     w_cond_met =  w_flags[FLAG_V];
      COND_OVERFLOW_CLEARED: w_cond_met = !w_flags[FLAG_V];
      default:               w_cond_met = 1'b0;
    endcase
  end

  assign w_taken = jump_branch_select & (unconditional_branch | w_cond_met);

  // Priority: ret > call > taken branch > sequential
  always_comb begin
    w_pc_nxt  = w_seq_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (r_count != '0) begin
          w_pc_nxt = ras_top;
          w_pop    = 1'b1;
        end else begin
          w_unf_set = 1'b1;
        end
      end else if (call) begin
        w_pc_nxt  = w_target;
        w_push    = 1'b1;
        w_ovf_set = (r_count == CNT_W'(RAS_DEPTH));
      end else if (w_taken) begin
        w_pc_nxt = w_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_VECTOR;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (!stall) begin
      r_pc <= w_pc_nxt;
      if (w_push) begin
        // When full the ring write lands on the oldest entry
        r_ras[r_wr_ptr] <= w_seq_pc;
        r_wr_ptr        <= w_ptr_inc;
        if (!w_ovf_set) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_wr_ptr <= w_ptr_dec;
        r_count  <= r_count - 1'b1;
      end
    end
  end

  // Set events win over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (clear_flags) r_ovf <= 1'b0;
      if (w_unf_set)        r_unf <= 1'b1;
      else if (clear_flags) r_unf <= 1'b0;
    end
  end

  assign pc            = r_pc;
  assign ras_top       = (r_count != '0) ? r_ras[w_ptr_dec] : '0;
  assign ras_count     = r_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  import program_counter_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic [11:0]       imar;
  logic [11:0]       address_immediate;
  logic              immediate_select;
  logic              relative_select;
  logic              jump_branch_select;
  logic              unconditional_branch;
  logic              call;
  logic              ret;
  logic [7:0]        status_register;
  branch_condition_e branch_condition;
  logic              clear_flags;
  logic [11:0]       pc;
  logic [11:0]       ras_top;
  logic [2:0]        ras_count;
  logic              ras_overflow;
  logic              ras_underflow;

  pc_sequencer #(
    .I_ADDR_W(12), .INST_W_BYTES(2), .DATA_W(8), .RAS_DEPTH(4), .RESET_VECTOR(12'h100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imar(imar),
    .address_immediate(address_immediate), .immediate_select(immediate_select),
    .relative_select(relative_select), .jump_branch_select(jump_branch_select),
    .unconditional_branch(unconditional_branch), .call(call), .ret(ret),
    .status_register(status_register), .branch_condition(branch_condition),
    .clear_flags(clear_flags), .pc(pc), .ras_top(ras_top), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] pc;
    logic [11:0] top;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle after each edge; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",            int'(pc),            int'(e.pc));
        chk("ras_top",       int'(ras_top),       int'(e.top));
        chk("ras_count",     int'(ras_count),     int'(e.cnt));
        chk("ras_overflow",  int'(ras_overflow),  int'(e.ovf));
        chk("ras_underflow", int'(ras_underflow), int'(e.unf));
      end
    end
  end

  task automatic idle();
    stall = 0; imar = '0; address_immediate = '0; immediate_select = 0;
    relative_select = 0; jump_branch_select = 0; unconditional_branch = 0;
    call = 0; ret = 0; status_register = '0; branch_condition = COND_ZERO;
    clear_flags = 0;
  endtask

  // Inputs are already driven; queue the state expected after the next edge
  task automatic cyc(input logic [11:0] p, input logic [11:0] t, input logic [2:0] c,
                     input logic o, input logic u);
    q.push_back('{pc: p, top: t, cnt: c, ovf: o, unf: u});
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic jmp_imm(input logic [11:0] a);
    jump_branch_select = 1; unconditional_branch = 1; immediate_select = 1;
    address_immediate = a;
  endtask

  task automatic call_imm(input logic [11:0] a);
    call = 1; immediate_select = 1; address_immediate = a;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_pc",    int'(pc),        'h100);
    chk("rst_count", int'(ras_count), 0);
    chk("rst_top",   int'(ras_top),   0);
    chk("rst_flags", int'({ras_overflow, ras_underflow}), 0);
    @(posedge clk); #2;
    rst_n = 1;

    // Sequential fetch from the reset vector
    cyc(12'h102, 12'h000, 3'd0, 0, 0);
    cyc(12'h104, 12'h000, 3'd0, 0, 0);
    cyc(12'h106, 12'h000, 3'd0, 0, 0);

    // Single call / return
    jmp_imm(12'h010);  cyc(12'h010, 12'h000, 3'd0, 0, 0);
    call_imm(12'h200); cyc(12'h200, 12'h012, 3'd1, 0, 0);
    ret = 1;           cyc(12'h012, 12'h000, 3'd0, 0, 0);

    // Five nested calls into a 4-deep RAS
    call_imm(12'h300); cyc(12'h300, 12'h014, 3'd1, 0, 0);
    call_imm(12'h400); cyc(12'h400, 12'h302, 3'd2, 0, 0);
    call_imm(12'h500); cyc(12'h500, 12'h402, 3'd3, 0, 0);
    call_imm(12'h600); cyc(12'h600, 12'h502, 3'd4, 0, 0);
    call_imm(12'h700); cyc(12'h700, 12'h602, 3'd4, 1, 0);
    ret = 1;           cyc(12'h602, 12'h502, 3'd3, 1, 0);
    ret = 1;           cyc(12'h502, 12'h402, 3'd2, 1, 0);
    ret = 1;           cyc(12'h402, 12'h302, 3'd1, 1, 0);
    ret = 1;           cyc(12'h302, 12'h000, 3'd0, 1, 0);
    ret = 1;           cyc(12'h304, 12'h000, 3'd0, 1, 1);
    clear_flags = 1;   cyc(12'h306, 12'h000, 3'd0, 0, 0);
    ret = 1; clear_flags = 1; cyc(12'h308, 12'h000, 3'd0, 0, 1);
    clear_flags = 1;   cyc(12'h30A, 12'h000, 3'd0, 0, 0);

    // Address wrap, relative and sequential
    jmp_imm(12'hFFE);  cyc(12'hFFE, 12'h000, 3'd0, 0, 0);
    jmp_imm(12'h004); relative_select = 1; cyc(12'h002, 12'h000, 3'd0, 0, 0);
    jmp_imm(12'hFFE);  cyc(12'hFFE, 12'h000, 3'd0, 0, 0);
    cyc(12'h000, 12'h000, 3'd0, 0, 0);

    // Conditional branches
    jump_branch_select = 1; immediate_select = 1; address_immediate = 12'h080;
    branch_condition = COND_ZERO; status_register = 8'h00;
    cyc(12'h002, 12'h000, 3'd0, 0, 0);
    jump_branch_select = 1; immediate_select = 1; address_immediate = 12'h080;
    branch_condition = COND_ZERO; status_register = 8'h01;
    cyc(12'h080, 12'h000, 3'd0, 0, 0);
    jump_branch_select = 1; immediate_select = 1; address_immediate = 12'h0C0;
    branch_condition = COND_NOT_ZERO; status_register = 8'h01;
    cyc(12'h082, 12'h000, 3'd0, 0, 0);
    jump_branch_select = 1; immediate_select = 1; address_immediate = 12'h0A0;
    branch_condition = COND_CARRY_SET; status_register = 8'h02;
    cyc(12'h0A0, 12'h000, 3'd0, 0, 0);

    // Stall blocks a call; register-indirect jump leaves RAS alone
    call_imm(12'h200); cyc(12'h200, 12'h0A2, 3'd1, 0, 0);
    call_imm(12'h300); stall = 1; cyc(12'h200, 12'h0A2, 3'd1, 0, 0);
    jump_branch_select = 1; unconditional_branch = 1; imar = 12'h250;
    cyc(12'h250, 12'h0A2, 3'd1, 0, 0);

    // call & ret together: pop only
    call_imm(12'h400); ret = 1; cyc(12'h0A2, 12'h000, 3'd0, 0, 0);

    // Fill past depth, then async reset mid-stack
    call_imm(12'h500); cyc(12'h500, 12'h0A4, 3'd1, 0, 0);
    call_imm(12'h600); cyc(12'h600, 12'h502, 3'd2, 0, 0);
    call_imm(12'h700); cyc(12'h700, 12'h602, 3'd3, 0, 0);
    call_imm(12'h710); cyc(12'h710, 12'h702, 3'd4, 0, 0);
    call_imm(12'h720); cyc(12'h720, 12'h712, 3'd4, 1, 0);
    #1;
    rst_n = 0;
    #1;
    chk("arst_pc",    int'(pc),        'h100);
    chk("arst_count", int'(ras_count), 0);
    chk("arst_top",   int'(ras_top),   0);
    chk("arst_flags", int'({ras_overflow, ras_underflow}), 0);
    #10;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
